// File: rtl/ex_muldiv_unit_pkg.sv
// Shared RISC-V definitions for the EX-stage multiply/divide unit.
// Holds the operation encoding, the FSM state encoding and the datapath constants.
package ex_muldiv_unit_pkg;

    localparam int XLEN       = 32;
    localparam int ITERATIONS = 32;
    localparam int CNT_W      = $clog2(ITERATIONS);

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        DIV    = 3'd4,
        DIVU   = 3'd5,
        REM    = 3'd6,
        REMU   = 3'd7
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } muldiv_state_t;

    function automatic logic opIsDiv(input muldiv_op_t o);
        return o[2];
    endfunction

    function automatic logic opIsRem(input muldiv_op_t o);
        return o[2] & o[1];
    endfunction

endpackage

// File: rtl/ex_muldiv_unit.sv
// Iterative radix-2 multiply/divide unit for the EX stage (RV32M).
// Operands are handled as magnitudes; the sign is re-applied once in FIX.
module ex_muldiv_unit
    import ex_muldiv_unit_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  muldiv_op_t      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    muldiv_state_t     state_q, state_d;
    muldiv_op_t        op_q, op_d;
    logic [XLEN-1:0]   operand_q, operand_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              neg_q, neg_d;
    logic              fast_q, fast_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              accept;
    logic              rs1Neg, rs2Neg;
    logic [XLEN-1:0]   rs1Abs, rs2Abs;
    logic              resNeg;
    logic              divZero, divOvf;
    logic [XLEN-1:0]   fastVal;
    logic [XLEN:0]     mulSum;
    logic [2*XLEN-1:0] mulNext;
    logic [XLEN+1:0]   divTrial;
    logic [2*XLEN-1:0] divNext;
    logic [2*XLEN-1:0] prodFixed;
    logic [XLEN-1:0]   quoFixed, remFixed;

    assign accept = ((state_q == IDLE) || (state_q == DONE)) && start;

    // Operand decode for the request presented this cycle.
    always_comb begin
        rs1Neg  = ((op == MULH) || (op == MULHSU) || (op == DIV) || (op == REM)) && rs1[XLEN-1];
        rs2Neg  = ((op == MULH) || (op == DIV) || (op == REM)) && rs2[XLEN-1];
        rs1Abs  = rs1Neg ? (~rs1 + 1'b1) : rs1;
        rs2Abs  = rs2Neg ? (~rs2 + 1'b1) : rs2;
        resNeg  = opIsRem(op) ? rs1Neg : (rs1Neg ^ rs2Neg);
        divZero = opIsDiv(op) && (rs2 == '0);
        divOvf  = ((op == DIV) || (op == REM)) && (rs1 == INT_MIN) && (rs2 == '1);
        fastVal = '0;
        if (divZero) begin
            fastVal = opIsRem(op) ? rs1 : '1;
        end else if (divOvf) begin
            fastVal = opIsRem(op) ? '0 : INT_MIN;
        end
    end

    // One shift-add or restoring shift-subtract step on the 64-bit accumulator.
    always_comb begin
        mulSum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, operand_q} : '0);
        mulNext  = {mulSum, acc_q[XLEN-1:1]};
        divTrial = {1'b0, acc_q[2*XLEN-1:XLEN-1]} - {2'b00, operand_q};
        if (divTrial[XLEN+1]) begin
            divNext = {acc_q[2*XLEN-2:0], 1'b0};
        end else begin
            divNext = {divTrial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end
    end

    always_comb begin
        prodFixed = neg_q ? (~acc_q + 1'b1) : acc_q;
        quoFixed  = neg_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
        remFixed  = neg_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        operand_d = operand_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        fast_d    = fast_q;
        result_d  = result_q;

        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    state_d = IDLE;
                    if (accept) begin
                        op_d   = op;
                        neg_d  = resNeg;
                        cnt_d  = '0;
                        fast_d = divZero || divOvf;
                        if (divZero || divOvf) begin
                            operand_d = rs2Abs;
                            acc_d     = {{XLEN{1'b0}}, fastVal};
                            state_d   = FIX;
                        end else if (opIsDiv(op)) begin
                            operand_d = rs2Abs;
                            acc_d     = {{XLEN{1'b0}}, rs1Abs};
                            state_d   = CALC;
                        end else begin
                            operand_d = rs1Abs;
                            acc_d     = {{XLEN{1'b0}}, rs2Abs};
                            state_d   = CALC;
                        end
                    end
                end
                CALC: begin
                    acc_d = opIsDiv(op_q) ? divNext : mulNext;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(ITERATIONS - 1)) begin
                        state_d = FIX;
                    end
                end
                FIX: begin
                    state_d = DONE;
                    if (fast_q) begin
                        result_d = acc_q[XLEN-1:0];
                    end else begin
                        case (op_q)
                            MUL:                 result_d = acc_q[XLEN-1:0];
                            MULH, MULHSU, MULHU: result_d = prodFixed[2*XLEN-1:XLEN];
                            DIV, DIVU:           result_d = quoFixed;
                            REM, REMU:           result_d = remFixed;
                            default:             result_d = result_q;
                        endcase
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            op_q      <= MUL;
            operand_q <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            fast_q    <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            operand_q <= operand_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            fast_q    <= fast_d;
            result_q  <= result_d;
        end
    end

    // Reset forces stall low even while start is asserted.
    assign stall  = reset && (accept || (state_q == CALC) || (state_q == FIX));
    assign done   = (state_q == DONE);
    assign result = result_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed self-checking bench for ex_muldiv_unit: arithmetic results, latency,
// fast paths, flush, asynchronous reset abort and back-to-back issue.
module tb_ex_muldiv_unit;
    import ex_muldiv_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    muldiv_op_t  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        flush;
    logic        stall;
    logic        done;
    logic [31:0] result;

    int total = 0;
    int bad   = 0;

    ex_muldiv_unit dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .rs1    (rs1),
        .rs2    (rs2),
        .flush  (flush),
        .stall  (stall),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #2;
    endtask

    // Present a request in the current cycle (cycle 0); stall must rise combinationally.
    task automatic applyStimulus(input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b, input string tag);
        op    = o;
        rs1   = a;
        rs2   = b;
        start = 1'b1;
        #1;
        checkOutput({tag, "_stall_c0"}, {31'b0, stall}, 32'd1);
    endtask

    // Cross the accept edge, then wait (bounded) for done and check latency and result.
    task automatic waitDone(input string tag, input logic [31:0] expected, input int lat);
        int  cyc     = 1;
        bit  seen    = 1'b0;
        bit  stallOk = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        #1;
        while (cyc <= 40) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (!stall) stallOk = 1'b0;
            nextCycle();
            cyc++;
        end
        checkOutput({tag, "_done_seen"}, {31'b0, seen}, 32'd1);
        checkOutput({tag, "_latency"}, 32'(cyc), 32'(lat));
        checkOutput({tag, "_stall_busy"}, {31'b0, stallOk}, 32'd1);
        checkOutput({tag, "_stall_done"}, {31'b0, stall}, 32'd0);
        checkOutput({tag, "_result"}, result, expected);
    endtask

    task automatic runOp(input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expected, input int lat, input string tag);
        applyStimulus(o, a, b, tag);
        waitDone(tag, expected, lat);
    endtask

    // Bounded quiet window: no done pulse, stall low, result unchanged.
    task automatic expectQuiet(input string tag, input logic [31:0] keepResult);
        bit anyDone  = 1'b0;
        bit anyStall = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) anyDone = 1'b1;
            if (stall) anyStall = 1'b1;
            nextCycle();
        end
        checkOutput({tag, "_no_done"}, {31'b0, anyDone}, 32'd0);
        checkOutput({tag, "_no_stall"}, {31'b0, anyStall}, 32'd0);
        checkOutput({tag, "_result_kept"}, result, keepResult);
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b1;
        flush = 1'b0;
        op    = MUL;
        rs1   = 32'd0;
        rs2   = 32'd0;

        repeat (2) @(posedge clk);
        #2;
        checkOutput("reset_stall", {31'b0, stall}, 32'd0);
        checkOutput("reset_done", {31'b0, done}, 32'd0);
        checkOutput("reset_result", result, 32'd0);

        start = 1'b0;
        reset = 1'b1;
        #1;
        checkOutput("idle_stall", {31'b0, stall}, 32'd0);

        runOp(MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34, "mul_7_m3");
        runOp(MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, "mulhu_max");
        runOp(MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 34, "mulh_m1");
        runOp(MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 34, "mulhsu_m1_2");
        runOp(MULH,   32'h80000000, 32'h80000000, 32'h40000000, 34, "mulh_min_min");
        runOp(MUL,    32'hFFFFFFF9, 32'd6,        32'hFFFFFFD6, 34, "mul_m7_6");
        runOp(DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34, "div_m7_2");
        runOp(REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34, "rem_m7_2");
        runOp(DIVU,   32'd100,      32'd7,        32'd14,       34, "divu_100_7");
        runOp(REMU,   32'd100,      32'd7,        32'd2,        34, "remu_100_7");
        runOp(DIV,    32'h80000000, 32'd1,        32'h80000000, 34, "div_min_1");
        runOp(DIVU,   32'h00001234, 32'd0,        32'hFFFFFFFF, 2,  "divu_by0");
        runOp(REMU,   32'h00001234, 32'd0,        32'h00001234, 2,  "remu_by0");
        runOp(DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 2,  "div_by0");
        runOp(REM,    32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 2,  "rem_by0");
        runOp(DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2,  "div_ovf");
        runOp(REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 2,  "rem_ovf");

        // Result holds after DONE while idle.
        repeat (3) nextCycle();
        checkOutput("hold_done", {31'b0, done}, 32'd0);
        checkOutput("hold_result", result, 32'h00000000);

        // Flush in cycle 10 of a multiply.
        runOp(DIVU, 32'd100, 32'd7, 32'd14, 34, "pre_flush");
        applyStimulus(MUL, 32'd3, 32'd5, "flush_mul");
        nextCycle();
        start = 1'b0;
        repeat (9) nextCycle();
        flush = 1'b1;
        nextCycle();
        flush = 1'b0;
        #1;
        checkOutput("flush_c11_stall", {31'b0, stall}, 32'd0);
        checkOutput("flush_c11_done", {31'b0, done}, 32'd0);
        expectQuiet("flush_mul", 32'd14);

        // Start coincident with flush is ignored.
        op    = MUL;
        rs1   = 32'd9;
        rs2   = 32'd9;
        start = 1'b1;
        flush = 1'b1;
        nextCycle();
        start = 1'b0;
        flush = 1'b0;
        #1;
        checkOutput("flush_start_stall", {31'b0, stall}, 32'd0);
        expectQuiet("flush_start", 32'd14);

        // Asynchronous reset in cycle 15 of a divide.
        applyStimulus(DIV, 32'd1000, 32'd3, "rst_div");
        nextCycle();
        start = 1'b0;
        repeat (14) nextCycle();
        #1;
        reset = 1'b0;
        #1;
        checkOutput("rst_mid_stall", {31'b0, stall}, 32'd0);
        checkOutput("rst_mid_done", {31'b0, done}, 32'd0);
        checkOutput("rst_mid_result", result, 32'd0);
        nextCycle();
        reset = 1'b1;
        expectQuiet("rst_after", 32'd0);

        // Back-to-back: second request issued in the DONE cycle of the first.
        runOp(MUL, 32'd12, 32'd12, 32'd144, 34, "b2b_first");
        runOp(DIV, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 34, "b2b_second");
        nextCycle();
        checkOutput("b2b_idle_done", {31'b0, done}, 32'd0);
        checkOutput("b2b_hold", result, 32'hFFFFFFF2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_unit.md
EX_MULDIV_UNIT -- requirements
Module: ex_muldiv_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous reset, active-low (asserted at 0).
REQ-003 SHALL have port start, input, 1 bit: request a new operation on the ID/EX operands this cycle.
REQ-004 SHALL have port op, input, 3 bits, type muldiv_op_t: MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7.
REQ-005 SHALL have ports rs1 and rs2, input, 32 bits each: operands from ID/EX data1_out and data2_out.
REQ-006 SHALL have port flush, input, 1 bit: abort any operation in progress (branch/jump redirect).
REQ-007 SHALL have port stall, output, 1 bit: drives the pipeline busywait.
REQ-008 SHALL have port done, output, 1 bit: result valid this cycle.
REQ-009 SHALL have port result, output, 32 bits: registered result.

Function
REQ-010 SHALL implement FSM states IDLE, CALC, FIX, DONE.
REQ-011 SHALL accept start only in IDLE or DONE; SHALL ignore start in CALC and FIX.
REQ-012 At the accept edge, SHALL latch op, |rs1|, |rs2| and the result sign, clear the 5-bit iteration counter, and enter CALC.
- Signedness: MULH/DIV/REM sign both operands; MULHSU signs rs1 only; MULHU/DIVU/REMU/MUL are unsigned.
REQ-013 CALC SHALL perform one radix-2 step per cycle.
- Multiply: shift-add into a 64-bit product.
- Divide: restoring shift-subtract on a 64-bit remainder/quotient pair.
REQ-014 After exactly 32 CALC cycles (counter wraps 31->0), SHALL enter FIX.
REQ-015 FIX SHALL apply sign correction, register result, and enter DONE.
- MUL: low 32 bits of the product.
- MULH/MULHSU/MULHU: high 32 bits.
- Quotient sign: sign(rs1) XOR sign(rs2).
- Remainder sign: sign(rs1).
REQ-016 DONE SHALL last exactly one cycle with done=1.
- Returns to IDLE, or enters CALC if start is accepted in that cycle.
REQ-017 stall SHALL be combinational: 1 when (state is IDLE or DONE and start=1) or state is CALC or FIX; 0 otherwise.
REQ-018 Latency: done SHALL assert in the 34th cycle counting the accept edge as cycle 0 (CALC 1-32, FIX 33, DONE 34), except for the REQ-019 fast paths.
REQ-019 Divide-by-zero (rs2=0) and signed overflow (DIV/REM, rs1=0x80000000, rs2=0xFFFFFFFF) SHALL skip CALC and go from accept directly to FIX, so done asserts 2 cycles after the accept edge.
- Div-by-zero: DIV/DIVU=0xFFFFFFFF, REM/REMU=rs1.
- Overflow: DIV=0x80000000, REM=0.
REQ-020 result SHALL hold its value from DONE until the next FIX.
REQ-021 flush=1 SHALL force IDLE at the next edge from any state, with no done pulse and result unchanged.
- flush overrides a simultaneous start.

Reset
REQ-022 While reset=0, SHALL hold state=IDLE, stall=0, done=0, result=0, and all internal registers 0.
REQ-023 Reset asserted mid-operation SHALL abort immediately (asynchronous) with no done pulse after release.
REQ-024 After reset release, the first start SHALL be accepted at the first rising edge.

Structure
REQ-025 muldiv_op_t and the FSM state enum SHALL reside in the shared riscv package.
- XLEN=32 and the iteration count of 32 are package constants.
REQ-026 The block SHALL be a single module with no sub-modules, instantiated in the EX stage beside the ALU.
- Its stall is ORed into busywait for the IF/ID and ID/EX pipes.

Verification
REQ-027 MUL rs1=7, rs2=0xFFFFFFFD -> result 0xFFFFFFEB with done in cycle 34; stall=1 in cycles 0-33, 0 in cycle 34.
REQ-028 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
REQ-029 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU 100 / 7 -> 2.
REQ-030 DIVU 0x1234 / 0 -> 0xFFFFFFFF and REMU -> 0x1234, done at cycle 2; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 and REM -> 0, done at cycle 2.
REQ-031 Start MUL, flush in cycle 10 -> IDLE in cycle 11, no done, result unchanged; start in the same cycle as flush -> ignored.
REQ-032 Start DIV, reset=0 in cycle 15 -> outputs 0 immediately and no done after release; back-to-back start in DONE -> second result in cycle 34 after that DONE.
